// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// Shift-add multiply and restoring divide run on magnitudes; the sign is applied in FIX.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] Ainput,
  input  logic [WIDTH-1:0] Binput,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  // state | meaning
  // IDLE  | waiting for start, accepts mthi/mtlo
  // RUN   | one multiply or divide step per edge, WIDTH steps
  // FIX   | sign correction, HI/LO write, done pulse
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div0;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   dvsr;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  logic               sgn;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] p_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  always_comb begin
    sgn   = op[0];
    a_abs = (sgn && Ainput[WIDTH-1]) ? -Ainput : Ainput;
    b_abs = (sgn && Binput[WIDTH-1]) ? -Binput : Binput;
    // trial[WIDTH] set means the shifted remainder is below the divisor
    trial = {rem, quot[WIDTH-1]} - {1'b0, dvsr};
    p_fix = neg_res ? -acc : acc;
    q_fix = div0 ? '1 : (neg_res ? -quot : quot);
    r_fix = neg_rem ? -rem : rem;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      dvsr    <= '0;
      quot    <= '0;
      rem     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            cnt     <= '0;
            is_div  <= op[1];
            neg_res <= sgn & (Ainput[WIDTH-1] ^ Binput[WIDTH-1]);
            neg_rem <= sgn & op[1] & Ainput[WIDTH-1];
            div0    <= (Binput == '0);
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, a_abs};
            mplier  <= b_abs;
            dvsr    <= b_abs;
            quot    <= a_abs;
            rem     <= '0;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: begin
          if (is_div) begin
            if (!trial[WIDTH]) begin
              rem  <= trial[WIDTH-1:0];
              quot <= {quot[WIDTH-2:0], 1'b1};
            end else begin
              rem  <= {rem[WIDTH-2:0], quot[WIDTH-1]};
              quot <= {quot[WIDTH-2:0], 1'b0};
            end
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (is_div) begin
            hi <= r_fix;
            lo <= q_fix;
          end else begin
            {hi, lo} <= p_fix;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
